bool_sweep_ctrl: RTL and testbench
==================================

Name: bool_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises a small combinational boolean datapath, such as our 3-input sum-of-products function blocks.
- Drives every input combination in ascending order and waits a programmable settle time before sampling the function output.
- Compares the captured truth table against an expected mask and reports pass/fail, mismatch count and first failing index.
- Sits beside the function block as a built-in self-test controller under a simple start/done handshake.

Parameters:
- N_IN, 3, number of function inputs; number of vectors NV = 2**N_IN. Legal range 1..6.
- SETTLE_CYCLES, 2, idle cycles between driving a vector and sampling dut_f. 0 is legal.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin sweep; honoured only in IDLE.
- abort  input  1  synchronous cancel of a running sweep.
- expected  input  NV  expected truth table; bit i = F for input vector i. Captured at start.
- dut_in  output  N_IN  vector driven to the datapath; MSB = a, LSB = c for N_IN=3.
- dut_f  input  1  datapath function output.
- busy  output  1  high in SETTLE and SAMPLE.
- done  output  1  one-cycle pulse when a sweep completes (not on abort).
- pass  output  1  result == captured expected; valid from done until next start.
- result  output  NV  captured truth table; bit i = dut_f sampled for vector i.
- fail_cnt  output  N_IN+1  number of mismatching vectors.
- first_fail  output  N_IN  lowest mismatching index; 0 if none.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dut_in, result, fail_cnt and first_fail all 0; busy=0, done=0, pass=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE + start=1 (abort=0) at a clock edge:
  - capture expected;
  - clear result, fail_cnt, first_fail and pass;
  - idx=0, dut_in=0, settle counter=SETTLE_CYCLES;
  - go to SETTLE.
- SETTLE:
  - counter nonzero: decrement each cycle.
  - counter 0: go to SAMPLE. With SETTLE_CYCLES=0, SETTLE lasts exactly one cycle.
  - Correction, normative: SETTLE lasts max(SETTLE_CYCLES,1) cycles, then SAMPLE.
- SAMPLE (one cycle):
  - At the edge: result[idx] <= dut_f.
  - If dut_f != expected_q[idx]: increment fail_cnt; if this is the first mismatch of the sweep, first_fail <= idx.
  - If idx == NV-1: go to DONE.
  - Otherwise: idx+1, dut_in <= idx+1, counter reload, go to SETTLE.
- Cost per vector: max(SETTLE_CYCLES,1)+1 cycles.
- done asserts NV*(max(SETTLE_CYCLES,1)+1) cycles after the start edge.
- DONE (one cycle): done=1, pass=(fail_cnt==0) registered on entry; dut_in returns to 0; next state IDLE.
- Outputs result, fail_cnt, first_fail and pass hold until the next accepted start.
- abort=1 in SETTLE, SAMPLE or DONE: next state IDLE, dut_in=0, no done pulse, pass=0; partial result and fail_cnt retained. abort has priority over the SAMPLE capture in the same cycle.
- start and abort both high in IDLE: abort wins; stay IDLE.
- start while busy or in DONE: ignored.
- idx counter is N_IN bits wide with no wrap; the terminal compare is against NV-1.
- fail_cnt saturates by construction: maximum value NV fits in N_IN+1 bits.
- dut_f is synchronous to clk and is not resynchronised.
- Reset asserted mid-sweep: immediate return to reset values.

Test Plan:
- N_IN=3, S=2, DUT F = ~b&c, expected=8'h22, pulse start → dut_in steps 0..7 every 3 cycles; done at cycle 24 after start edge; result=8'h22, pass=1, fail_cnt=0, first_fail=0.
- Same DUT, expected=8'h23 → result=8'h22, pass=0, fail_cnt=1, first_fail=0.
- Same DUT, expected=8'hDD (full inversion) → fail_cnt=8, first_fail=0, pass=0; then expected=8'h2A → fail_cnt=1, first_fail=3.
- S=0 → each vector takes 2 cycles; done at cycle 16; result still 8'h22.
- abort asserted during vector 4 SETTLE → IDLE next cycle, dut_in=0, no done pulse, result bits 0..3 = 4'h2; restarting with start gives the full 8'h22 run.
- rst_n low during vector 2 SAMPLE → all outputs 0 immediately; start pressed during busy → ignored with no sweep restart; start with abort high in IDLE → no sweep.

Source files
------------

// File: rtl/bool_sweep_if.sv
// Start/done handshake, expected/result table and datapath drive/sense for bool_sweep_ctrl.
// The master is the host plus the function block under test; the slave is the controller.
interface bool_sweep_if #(
  parameter int unsigned N_IN = 3
);
  localparam int unsigned Nv = 1 << N_IN;

  logic            start;
  logic            abort;
  logic [Nv-1:0]   expected;
  logic [N_IN-1:0] dut_in;
  logic            dut_f;
  logic            busy;
  logic            done;
  logic            pass;
  logic [Nv-1:0]   result;
  logic [N_IN:0]   fail_cnt;
  logic [N_IN-1:0] first_fail;

  modport master (
    output start, abort, expected, dut_f,
    input  dut_in, busy, done, pass, result, fail_cnt, first_fail
  );

  modport slave (
    input  start, abort, expected, dut_f,
    output dut_in, busy, done, pass, result, fail_cnt, first_fail
  );
endinterface

// File: rtl/bool_sweep_ctrl.sv
// Built-in self-test sequencer: sweeps every input vector of a small boolean block,
// waits a settle time, samples its output and scores the truth table against a mask.
module bool_sweep_ctrl #(
  parameter int unsigned N_IN          = 3,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input logic         clk,
  input logic         rst_n,
  bool_sweep_if.slave bus
);
  localparam int unsigned Nv   = 1 << N_IN;
  localparam int unsigned CntW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES);
  localparam logic [N_IN-1:0] LastIdx    = N_IN'(Nv - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [N_IN-1:0] idx_q;
  logic [N_IN-1:0] dut_in_q;
  logic [N_IN-1:0] first_fail_q;
  logic [Nv-1:0]   expected_q;
  logic [Nv-1:0]   result_q;
  logic [N_IN:0]   fail_cnt_q;
  logic            done_q;
  logic            pass_q;
  logic            mismatch;

  assign mismatch = bus.dut_f ^ expected_q[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      idx_q        <= '0;
      dut_in_q     <= '0;
      first_fail_q <= '0;
      expected_q   <= '0;
      result_q     <= '0;
      fail_cnt_q   <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start && !bus.abort) begin
            expected_q   <= bus.expected;
            result_q     <= '0;
            fail_cnt_q   <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
            idx_q        <= '0;
            dut_in_q     <= '0;
            cnt_q        <= SettleLoad;
            state_q      <= StSettle;
          end
        end
        StSettle: begin
          if (bus.abort) begin
            state_q  <= StIdle;
            dut_in_q <= '0;
            pass_q   <= 1'b0;
          // Leaving at count 1 (or 0) gives max(SETTLE_CYCLES,1) settle cycles.
          end else if (cnt_q <= CntW'(1)) begin
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StSample: begin
          if (bus.abort) begin
            state_q  <= StIdle;
            dut_in_q <= '0;
            pass_q   <= 1'b0;
          end else begin
            result_q[idx_q] <= bus.dut_f;
            if (mismatch) begin
              fail_cnt_q <= fail_cnt_q + (N_IN + 1)'(1);
              if (fail_cnt_q == '0) first_fail_q <= idx_q;
            end
            if (idx_q == LastIdx) begin
              state_q  <= StDone;
              done_q   <= 1'b1;
              dut_in_q <= '0;
              pass_q   <= (fail_cnt_q == '0) && !mismatch;
            end else begin
              idx_q    <= idx_q + N_IN'(1);
              dut_in_q <= idx_q + N_IN'(1);
              cnt_q    <= SettleLoad;
              state_q  <= StSettle;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          if (bus.abort) pass_q <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy       = (state_q == StSettle) || (state_q == StSample);
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.dut_in     = dut_in_q;
  assign bus.result     = result_q;
  assign bus.fail_cnt   = fail_cnt_q;
  assign bus.first_fail = first_fail_q;
endmodule

// File: tb/tb_bool_sweep_ctrl.sv
// Self-checking bench: two controllers (settle 2 and settle 0) against an elapsed-cycle model,
// directed scenarios with literal expectations, then randomized sweeps with aborts.
module tb_bool_sweep_ctrl;
  localparam int unsigned N_IN = 3;
  localparam int NV = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] func_mask = 8'h22;

  bool_sweep_if #(.N_IN(N_IN)) bus0 ();
  bool_sweep_if #(.N_IN(N_IN)) bus1 ();

  bool_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYCLES(2)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  bool_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYCLES(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Function block under test: truth table held in func_mask.
  assign bus0.dut_f = func_mask[bus0.dut_in];
  assign bus1.dut_f = func_mask[bus1.dut_in];

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int per_vec [2] = '{3, 2};
  int sc [2];
  int dc [2];
  logic [2:0] tr [64];

  // Model: edges since the start edge, vectors sampled so far, captured masks.
  bit         m_run  [2];
  int         m_k    [2];
  int         m_ns   [2];
  bit         m_pass [2];
  logic [7:0] m_exp  [2];
  logic [7:0] m_fm   [2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int popc(input logic [7:0] x);
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(x[i]);
    return n;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_run[d] = 0; m_k[d] = 0; m_ns[d] = 0; m_pass[d] = 0; m_exp[d] = '0; m_fm[d] = '0;
    end
  endtask

  task automatic model_edge(input int d, input bit st, input bit ab, input logic [7:0] ex);
    int lim = NV * per_vec[d];
    if (!m_run[d]) begin
      if (st && !ab) begin
        m_run[d] = 1; m_k[d] = 0; m_ns[d] = 0; m_pass[d] = 0;
        m_exp[d] = ex; m_fm[d] = func_mask;
      end
    end else if (m_k[d] < lim) begin
      if (ab) begin
        m_run[d] = 0; m_pass[d] = 0;
      end else begin
        m_k[d]++;
        if (m_k[d] % per_vec[d] == 0) m_ns[d] = m_k[d] / per_vec[d];
        if (m_k[d] == lim) m_pass[d] = (m_fm[d] == m_exp[d]);
      end
    end else begin
      m_run[d] = 0;
      if (ab) m_pass[d] = 0;
    end
  endtask

  task automatic check_dut(input int d, input logic [2:0] din, input logic busy, input logic done,
                           input logic pass, input logic [7:0] res, input logic [3:0] fc,
                           input logic [2:0] ff);
    int lim, msk, first, edin;
    bit eb, ed;
    logic [7:0] x;
    string p;
    lim  = NV * per_vec[d];
    eb   = m_run[d] && (m_k[d] < lim);
    ed   = m_run[d] && (m_k[d] == lim);
    edin = eb ? m_k[d] / per_vec[d] : 0;
    msk  = (1 << m_ns[d]) - 1;
    x    = (m_fm[d] ^ m_exp[d]) & msk[7:0];
    first = 0;
    for (int i = 7; i >= 0; i--) if (x[i]) first = i;
    p = (d == 0) ? "s2" : "s0";
    chk({p, ".dut_in"}, int'(din), edin);
    chk({p, ".busy"}, int'(busy), int'(eb));
    chk({p, ".done"}, int'(done), int'(ed));
    chk({p, ".pass"}, int'(pass), int'(m_pass[d]));
    chk({p, ".result"}, int'(res), int'(m_fm[d] & msk[7:0]));
    chk({p, ".fail_cnt"}, int'(fc), popc(x));
    chk({p, ".first_fail"}, int'(ff), first);
  endtask

  task automatic check_all();
    check_dut(0, bus0.dut_in, bus0.busy, bus0.done, bus0.pass, bus0.result, bus0.fail_cnt,
              bus0.first_fail);
    check_dut(1, bus1.dut_in, bus1.busy, bus1.done, bus1.pass, bus1.result, bus1.fail_cnt,
              bus1.first_fail);
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_edge(0, bus0.start, bus0.abort, bus0.expected);
      model_edge(1, bus1.start, bus1.abort, bus1.expected);
    end
    cyc++;
    @(negedge clk);
    check_all();
    if (cyc - sc[0] >= 0 && cyc - sc[0] < 64) tr[cyc - sc[0]] = bus0.dut_in;
    if (bus0.done && dc[0] < 0) dc[0] = cyc - sc[0];
    if (bus1.done && dc[1] < 0) dc[1] = cyc - sc[1];
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (n < bound && (m_run[0] || m_run[1] || bus0.busy || bus1.busy || bus0.done ||
                         bus1.done)) begin
      step();
      n++;
    end
    if (n >= bound) chk("idle_timeout", n, -1);
  endtask

  task automatic arm(input logic [7:0] fm, input logic [7:0] ex, input bit u0, input bit u1);
    func_mask = fm;
    bus0.expected = ex; bus1.expected = ex;
    bus0.start = u0; bus1.start = u1;
    sc[0] = cyc + 1; sc[1] = cyc + 1; dc[0] = -1; dc[1] = -1;
    step();
    bus0.start = 1'b0; bus1.start = 1'b0;
  endtask

  task automatic sweep(input logic [7:0] fm, input logic [7:0] ex, input bit u0, input bit u1);
    arm(fm, ex, u0, u1);
    wait_idle(80);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus0.start = 0; bus0.abort = 0; bus0.expected = '0;
    bus1.start = 0; bus1.abort = 0; bus1.expected = '0;
    sc[0] = 0; sc[1] = 0; dc[0] = -1; dc[1] = -1;
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Matching table: ~b&c.
    sweep(8'h22, 8'h22, 1, 1);
    chk("lit_done_cyc_s2", dc[0], 24);
    chk("lit_done_cyc_s0", dc[1], 16);
    chk("lit_din_k0", int'(tr[0]), 0);
    chk("lit_din_k3", int'(tr[3]), 1);
    chk("lit_din_k21", int'(tr[21]), 7);
    chk("lit_din_k24", int'(tr[24]), 0);
    chk("lit_res_s2", int'(bus0.result), 8'h22);
    chk("lit_res_s0", int'(bus1.result), 8'h22);
    chk("lit_pass", int'(bus0.pass), 1);
    chk("lit_fc", int'(bus0.fail_cnt), 0);

    sweep(8'h22, 8'h23, 1, 1);
    chk("lit_23_fc", int'(bus0.fail_cnt), 1);
    chk("lit_23_ff", int'(bus0.first_fail), 0);
    chk("lit_23_pass", int'(bus0.pass), 0);
    chk("lit_23_res", int'(bus0.result), 8'h22);

    sweep(8'h22, 8'hDD, 1, 1);
    chk("lit_dd_fc", int'(bus0.fail_cnt), 8);
    chk("lit_dd_ff", int'(bus1.first_fail), 0);
    sweep(8'h22, 8'h2A, 1, 1);
    chk("lit_2a_fc", int'(bus0.fail_cnt), 1);
    chk("lit_2a_ff", int'(bus0.first_fail), 3);
    chk("lit_2a_ff_s0", int'(bus1.first_fail), 3);

    // Abort during vector 4 settle.
    arm(8'h22, 8'h22, 1, 0);
    repeat (12) step();
    bus0.abort = 1'b1;
    step();
    bus0.abort = 1'b0;
    chk("lit_abort_busy", int'(bus0.busy), 0);
    chk("lit_abort_din", int'(bus0.dut_in), 0);
    chk("lit_abort_res", int'(bus0.result), 8'h02);
    repeat (30) step();
    chk("lit_abort_no_done", dc[0], -1);
    sweep(8'h22, 8'h22, 1, 0);
    chk("lit_restart_res", int'(bus0.result), 8'h22);
    chk("lit_restart_pass", int'(bus0.pass), 1);

    // Start while busy must not restart the sweep.
    arm(8'h22, 8'h22, 1, 0);
    repeat (5) step();
    bus0.start = 1'b1;
    step();
    bus0.start = 1'b0;
    wait_idle(80);
    chk("lit_busy_start_done", dc[0], 24);

    // Reset during vector 2 sample.
    arm(8'h22, 8'hDD, 1, 0);
    repeat (8) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("lit_rst_busy", int'(bus0.busy), 0);
    chk("lit_rst_res", int'(bus0.result), 0);
    chk("lit_rst_fc", int'(bus0.fail_cnt), 0);
    chk("lit_rst_din", int'(bus0.dut_in), 0);
    step();
    rst_n = 1'b1;
    step();

    // Start with abort in idle.
    bus0.start = 1; bus0.abort = 1; bus1.start = 1; bus1.abort = 1;
    step();
    bus0.start = 0; bus0.abort = 0; bus1.start = 0; bus1.abort = 0;
    chk("lit_startabort_s2", int'(bus0.busy), 0);
    chk("lit_startabort_s0", int'(bus1.busy), 0);

    // Randomized sweeps.
    for (int it = 0; it < 40; it++) begin
      logic [7:0] fm, ex;
      fm = 8'($urandom);
      ex = ($urandom_range(0, 2) == 0) ? fm : 8'($urandom);
      if ($urandom_range(0, 3) == 0) ex = fm ^ (8'h1 << $urandom_range(0, 7));
      arm(fm, ex, 1, $urandom_range(0, 1) == 1);
      for (int c = 0; c < 60; c++) begin
        bus0.abort = ($urandom_range(0, 39) == 0);
        bus1.abort = ($urandom_range(0, 39) == 0);
        bus0.start = ($urandom_range(0, 9) == 0);
        bus1.start = ($urandom_range(0, 9) == 0);
        step();
      end
      bus0.start = 0; bus0.abort = 0; bus1.start = 0; bus1.abort = 0;
      wait_idle(80);
      repeat ($urandom_range(0, 3)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
